uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..9).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port baud_tick  input  1  one-cycle pulse per bit time.
REQ-006 SHALL have port in_valid  input  1  upstream has a byte.
REQ-007 SHALL have port in_data  input  DATA_BITS  byte to send, LSB first.
REQ-008 SHALL have port in_ready  output  1  holding register empty, can accept.
REQ-009 SHALL have port parity_en  input  1  insert parity bit (effective only with macro).
REQ-010 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even (effective only with macro).
REQ-011 SHALL have port tx_line  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  frame in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at end of each frame.

Function
REQ-014 SHALL hold one entry in a holding register; in_ready = holding register empty, registered, no combinational path from in_valid.
REQ-015 SHALL accept in_data on an edge where in_valid && in_ready; in_valid while in_ready=0 SHALL be ignored, no data lost or overwritten.
REQ-016 SHALL use states IDLE, START, DATA, PARITY, STOP; busy = (state != IDLE).
REQ-017 SHALL, in IDLE with holding register full, load the shifter on the next edge, enter START, drive tx_line=0, and free the holding register (in_ready=1 next cycle).
REQ-018 SHALL latency: accept at edge E0, tx_line low from edge E0+1.
REQ-019 SHALL advance one bit per baud_tick: START -> DATA (DATA_BITS bits, LSB first) -> PARITY (if enabled) -> STOP (STOP_BITS bits); tx_line updates on the same edge as the transition.
REQ-020 SHALL hold state and tx_line unchanged in cycles without baud_tick.
REQ-021 SHALL drive tx_line=1 in STOP and IDLE.
REQ-022 SHALL sample parity_en and parity_odd at shifter load and use those values for the whole frame.
REQ-023 SHALL compute the parity bit as XOR of the DATA_BITS data bits, inverted when parity_odd=1.
REQ-024 SHALL pulse done for exactly one cycle on the baud_tick edge that ends the last stop bit.
REQ-025 SHALL, at that edge with the holding register full, go directly to START (tx_line=0, busy stays 1, no idle cycle); otherwise go to IDLE (busy=0).
REQ-026 SHALL make the frame length 1 + DATA_BITS + P + STOP_BITS baud ticks, where P = 1 if parity is active, else 0.

Reset
REQ-027 SHALL, when rst_n=0 at a clk edge, set state=IDLE, tx_line=1, busy=0, done=0, in_ready=1, and clear the shifter, bit counter and holding register.
REQ-028 SHALL give reset priority over baud_tick and in_valid; a frame in progress SHALL be aborted and the line return high immediately.

Configuration
REQ-029 SHALL support macro UART_TX_PARITY_EN; when defined, PARITY state and parity_en/parity_odd are functional.
REQ-030 SHALL, without UART_TX_PARITY_EN, omit the PARITY state, ignore parity_en/parity_odd, and always send frames with no parity bit.
REQ-031 SHALL reject DATA_BITS outside 5..9 or STOP_BITS outside 1..2 at elaboration.

Verification
REQ-032 SHALL cover 8N1 with byte 0xA5: line 0,1,0,1,0,0,1,0,1,1 per tick; done once; busy low after.
REQ-033 SHALL cover 0x55 then 0x0F offered back-to-back: second start bit on the tick ending the first stop bit; no idle cycle; two done pulses.
REQ-034 SHALL cover, with macro, byte 0x07 and parity_en=1: parity bit 1 when parity_odd=0 and 0 when parity_odd=1; frame is 11 ticks.
REQ-035 SHALL cover DATA_BITS=7, STOP_BITS=2, byte 0x7F: frame is 10 ticks with two high stop bits.
REQ-036 SHALL cover in_valid held high while the holding register is full: in_ready=0; the queued byte is sent unchanged; the third byte is accepted only after the holding register drains.
REQ-037 SHALL cover rst_n=0 during DATA bit 3: next cycle tx_line=1, busy=0, in_ready=1, no done pulse.

Source files
------------

// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - upstream byte handshake into the UART transmitter holding register
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with one-entry holding register; parity under UART_TX_PARITY_EN
module uart_tx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         baud_tick,
  uart_tx_cfg_if.slave s_in,
  input  logic         parity_en,
  input  logic         parity_odd,
  output logic         tx_line,
  output logic         busy,
  output logic         done
);

  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_tx_cfg: DATA_BITS must be 5..9 and STOP_BITS 1..2");
  end

  localparam logic [3:0] LP_LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LP_LAST_STOP = 4'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_tx;
  logic                 r_done;
  logic [DATA_BITS-1:0] r_shift;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_hold_data;
  logic                 r_hold_full;

  logic                 w_tx_nxt;
  logic                 w_done_nxt;
  logic                 w_load;
  logic                 w_shift;
  logic                 w_cnt_clr;
  logic                 w_cnt_inc;
  logic                 w_accept;

`ifdef UART_TX_PARITY_EN
  // Frame-wide parity settings, captured when the shifter is loaded.
  logic                 r_par_en;
  logic                 r_par_bit;
`else
  logic                 w_unused_parity;
  assign w_unused_parity = parity_en ^ parity_odd;
`endif

  // Holding register is empty exactly when upstream may hand over a byte.
  assign s_in.in_ready = ~r_hold_full;
  assign w_accept      = s_in.in_valid & ~r_hold_full;

  assign tx_line = r_tx;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and per-edge datapath controls; the line value moves with the state.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (baud_tick) begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
          w_shift     = 1'b1;
          w_cnt_clr   = 1'b1;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (r_bit_cnt == LP_LAST_DATA) begin
            w_cnt_clr = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (r_par_en) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_par_bit;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
`else
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_tx_nxt  = r_shift[0];
            w_shift   = 1'b1;
            w_cnt_inc = 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
          w_cnt_clr   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_tick) begin
          if (r_bit_cnt == LP_LAST_STOP) begin
            w_done_nxt = 1'b1;
            if (r_hold_full) begin
              // Queued byte starts immediately: no idle cycle between frames.
              w_load      = 1'b1;
              w_state_nxt = S_START;
              w_tx_nxt    = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // Line driver, done pulse, shifter and bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_done <= w_done_nxt;
      if (w_load)       r_shift <= r_hold_data;
      else if (w_shift) r_shift <= r_shift >> 1;
      if (w_cnt_clr)      r_bit_cnt <= '0;
      else if (w_cnt_inc) r_bit_cnt <= r_bit_cnt + 4'd1;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity mode and bit are frozen at load so mid-frame input changes do not matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_load) begin
      r_par_en  <= parity_en;
      r_par_bit <= (^r_hold_data) ^ parity_odd;
    end
  end
`endif

  // Holding register: filled on handshake, emptied when the shifter takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_data <= s_in.in_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed vector bench for uart_tx_cfg (8N1 and 7-data/2-stop instances)
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic baud_tick = 1'b0;
  logic parity_en = 1'b0;
  logic parity_odd = 1'b0;
  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if_b ();

  uart_tx_cfg #(.DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_tick  (baud_tick),
    .s_in       (if_a),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .tx_line    (tx_a),
    .busy       (busy_a),
    .done       (done_a)
  );

  uart_tx_cfg #(.DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_tick  (baud_tick),
    .s_in       (if_b),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .tx_line    (tx_b),
    .busy       (busy_b),
    .done       (done_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         sel;
    logic [8:0] data;
    logic       pe;
    logic       po;
    int         n;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input string name, input bit sel, input logic [8:0] data,
                               input logic pe, input logic po, input int n, input logic [15:0] exp);
    vec_t v;
    v.name = name; v.sel = sel; v.data = data; v.pe = pe; v.po = po; v.n = n; v.exp = exp;
    return v;
  endfunction

  function automatic logic cur_tx(input bit sel);    return sel ? tx_b : tx_a;                 endfunction
  function automatic logic cur_busy(input bit sel);  return sel ? busy_b : busy_a;             endfunction
  function automatic logic cur_done(input bit sel);  return sel ? done_b : done_a;             endfunction
  function automatic logic cur_ready(input bit sel); return sel ? if_b.in_ready : if_a.in_ready; endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    baud_tick = 1'b1;
    @(posedge clk); #1;
    baud_tick = 1'b0;
  endtask

  // Hand one byte to an idle transmitter and stop once the start bit is on the line.
  task automatic offer(input bit sel, input logic [8:0] d, input logic pe, input logic po);
    int waited;
    waited = 0;
    parity_en  = pe;
    parity_odd = po;
    if (sel) begin if_b.in_valid = 1'b1; if_b.in_data = d[6:0]; end
    else     begin if_a.in_valid = 1'b1; if_a.in_data = d[7:0]; end
    while (!cur_ready(sel) && waited < 200) begin step(); waited++; end
    check("offer_ready", 32'(cur_ready(sel)), 32'd1);
    step();
    if (sel) if_b.in_valid = 1'b0; else if_a.in_valid = 1'b0;
    check("accept_line_still_idle", 32'(cur_tx(sel)), 32'd1);
    step();
    check("load_start_bit", 32'(cur_tx(sel)), 32'd0);
    check("load_busy", 32'(cur_busy(sel)), 32'd1);
    check("load_ready_again", 32'(cur_ready(sel)), 32'd1);
    parity_en  = ~pe;
    parity_odd = ~po;
  endtask

  // Record one frame that already shows its start bit; ticks are spaced by idle cycles.
  task automatic capture(input bit sel, input int n, output logic [15:0] bits,
                         output int dones, output int glitches, output int busy_lows);
    logic prev;
    bits = '0; dones = 0; glitches = 0; busy_lows = 0;
    bits[0] = cur_tx(sel);
    for (int k = 1; k <= n; k++) begin
      prev = cur_tx(sel);
      for (int g = 0; g < 2; g++) begin
        step();
        if (cur_tx(sel) !== prev) glitches++;
        if (cur_done(sel)) dones++;
        if (!cur_busy(sel)) busy_lows++;
      end
      tick();
      if (cur_done(sel)) dones++;
      if (k < n) begin
        bits[k] = cur_tx(sel);
        if (!cur_busy(sel)) busy_lows++;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int dones, gl, bl, total_dones;

    if_a.in_valid = 1'b0; if_a.in_data = '0;
    if_b.in_valid = 1'b0; if_b.in_data = '0;

    repeat (3) step();
    check("rst_tx_a", 32'(tx_a), 32'd1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_ready_a", 32'(if_a.in_ready), 32'd1);
    check("rst_tx_b", 32'(tx_b), 32'd1);
    check("rst_ready_b", 32'(if_b.in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Expected line bits, index 0 = start bit: {stop(s), [parity], data, start}.
    vecs.push_back(mkv("a5_8n1", 1'b0, 9'h0A5, 1'b0, 1'b0, 10, {6'd0, 1'b1, 8'hA5, 1'b0}));
    vecs.push_back(mkv("00_8n1", 1'b0, 9'h000, 1'b0, 1'b0, 10, {6'd0, 1'b1, 8'h00, 1'b0}));
    vecs.push_back(mkv("ff_8n1", 1'b0, 9'h0FF, 1'b0, 1'b0, 10, {6'd0, 1'b1, 8'hFF, 1'b0}));
    vecs.push_back(mkv("7f_7n2", 1'b1, 9'h07F, 1'b0, 1'b0, 10, {6'd0, 2'b11, 7'h7F, 1'b0}));
    vecs.push_back(mkv("2a_7n2", 1'b1, 9'h02A, 1'b0, 1'b0, 10, {6'd0, 2'b11, 7'h2A, 1'b0}));
`ifdef UART_TX_PARITY_EN
    vecs.push_back(mkv("07_even", 1'b0, 9'h007, 1'b1, 1'b0, 11, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}));
    vecs.push_back(mkv("07_odd",  1'b0, 9'h007, 1'b1, 1'b1, 11, {5'd0, 1'b1, 1'b0, 8'h07, 1'b0}));
    vecs.push_back(mkv("a5_odd",  1'b0, 9'h0A5, 1'b1, 1'b1, 11, {5'd0, 1'b1, 1'b1, 8'hA5, 1'b0}));
`else
    vecs.push_back(mkv("07_par_ignored", 1'b0, 9'h007, 1'b1, 1'b1, 10, {6'd0, 1'b1, 8'h07, 1'b0}));
`endif

    foreach (vecs[i]) begin
      offer(vecs[i].sel, vecs[i].data, vecs[i].pe, vecs[i].po);
      capture(vecs[i].sel, vecs[i].n, bits, dones, gl, bl);
      check({vecs[i].name, "_bits"}, 32'(bits), 32'(vecs[i].exp));
      check({vecs[i].name, "_done_at_end"}, 32'(cur_done(vecs[i].sel)), 32'd1);
      check({vecs[i].name, "_done_count"}, 32'(dones), 32'd1);
      check({vecs[i].name, "_hold_between_ticks"}, 32'(gl), 32'd0);
      check({vecs[i].name, "_busy_in_frame"}, 32'(bl), 32'd0);
      check({vecs[i].name, "_idle_line"}, 32'(cur_tx(vecs[i].sel)), 32'd1);
      check({vecs[i].name, "_idle_busy"}, 32'(cur_busy(vecs[i].sel)), 32'd0);
      step();
      check({vecs[i].name, "_done_one_cycle"}, 32'(cur_done(vecs[i].sel)), 32'd0);
    end

    // Back-to-back 0x55 then 0x0F: second start bit on the tick ending the first stop bit.
    offer(1'b0, 9'h055, 1'b0, 1'b0);
    if_a.in_valid = 1'b1; if_a.in_data = 8'h0F;
    step();
    if_a.in_valid = 1'b0;
    check("b2b_hold_full", 32'(if_a.in_ready), 32'd0);
    capture(1'b0, 10, bits, dones, gl, bl);
    total_dones = dones;
    check("b2b_first_bits", 32'(bits), 32'({6'd0, 1'b1, 8'h55, 1'b0}));
    check("b2b_first_done", 32'(done_a), 32'd1);
    check("b2b_second_start", 32'(tx_a), 32'd0);
    check("b2b_busy_kept", 32'(busy_a), 32'd1);
    check("b2b_ready_freed", 32'(if_a.in_ready), 32'd1);
    capture(1'b0, 10, bits, dones, gl, bl);
    total_dones += dones;
    check("b2b_second_bits", 32'(bits), 32'({6'd0, 1'b1, 8'h0F, 1'b0}));
    check("b2b_no_idle_cycle", 32'(bl), 32'd0);
    check("b2b_done_total", 32'(total_dones), 32'd2);
    check("b2b_end_busy", 32'(busy_a), 32'd0);
    step();

    // in_valid held while the holding register is full: queued byte must survive.
    if_a.in_valid = 1'b1; if_a.in_data = 8'h3C;
    step();
    if_a.in_data = 8'hC3;
    step();
    check("q_first_loaded", 32'(tx_a), 32'd0);
    step();
    if_a.in_data = 8'h99;
    check("q_full_not_ready", 32'(if_a.in_ready), 32'd0);
    capture(1'b0, 10, bits, dones, gl, bl);
    check("q_frame1_bits", 32'(bits), 32'({6'd0, 1'b1, 8'h3C, 1'b0}));
    check("q_frame2_started", 32'(tx_a), 32'd0);
    check("q_drained_ready", 32'(if_a.in_ready), 32'd1);
    step();
    if_a.in_valid = 1'b0;
    check("q_third_accepted", 32'(if_a.in_ready), 32'd0);
    capture(1'b0, 10, bits, dones, gl, bl);
    check("q_frame2_bits", 32'(bits), 32'({6'd0, 1'b1, 8'hC3, 1'b0}));
    check("q_frame3_started", 32'(tx_a), 32'd0);
    capture(1'b0, 10, bits, dones, gl, bl);
    check("q_frame3_bits", 32'(bits), 32'({6'd0, 1'b1, 8'h99, 1'b0}));
    check("q_end_busy", 32'(busy_a), 32'd0);
    step();

    // Reset during DATA bit 3 of 0xA5 (bit 3 = 0), with tick and valid also asserted.
    offer(1'b0, 9'h0A5, 1'b0, 1'b0);
    repeat (4) begin step(); tick(); end
    check("rst_mid_bit3", 32'(tx_a), 32'd0);
    check("rst_mid_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0; baud_tick = 1'b1; if_a.in_valid = 1'b1; if_a.in_data = 8'h33;
    step();
    rst_n = 1'b1; baud_tick = 1'b0; if_a.in_valid = 1'b0;
    check("rst_abort_tx", 32'(tx_a), 32'd1);
    check("rst_abort_busy", 32'(busy_a), 32'd0);
    check("rst_abort_ready", 32'(if_a.in_ready), 32'd1);
    check("rst_abort_done", 32'(done_a), 32'd0);
    dones = 0; gl = 0;
    repeat (12) begin
      step(); tick();
      if (done_a) dones++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0) gl++;
    end
    check("rst_after_no_done", 32'(dones), 32'd0);
    check("rst_after_line_idle", 32'(gl), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
